// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID pipeline register,
// a hold buffer for responses that arrive during a load-use stall, and stale-response dropping.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        stallF_load_hazard,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        validD,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        busy_q;
    logic        busy_d;
    logic        advance_s;
    logic [31:0] idle_instr_s;
    logic        idle_valid_s;
    logic        unused_target_bits_s;

    assign advance_s            = pc_write & stallF_load_hazard;
    assign unused_target_bits_s = ^PCTargetE[1:0];

    // IF/ID contents when nothing new enters: bubble if decode consumes, otherwise hold
    always_comb begin
        if (stallF_load_hazard) begin
            idle_instr_s = NOP_INSTR;
            idle_valid_s = 1'b0;
        end else begin
            idle_instr_s = instr_q;
            idle_valid_s = valid_q;
        end
    end

    // Next-state and IF/ID next-value selection; a redirect outranks every other event
    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        hold_d  = hold_q;
        instr_d = idle_instr_s;
        valid_d = idle_valid_s;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        if (PCSrcE) begin
            pcf_d   = {PCTargetE[31:2], 2'b00};
            hold_d  = 32'h0000_0000;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            case (state_q)
                IDLE:    state_d = DROP;
                WAIT:    state_d = imem_valid ? IDLE : DROP;
                HOLD:    state_d = IDLE;
                // A response landing now retires the dropped request; nothing else is outstanding
                DROP:    state_d = imem_valid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_valid && advance_s) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        pcd_d   = pcf_q;
                        pcp4_d  = pc_plus4(pcf_q);
                        pcf_d   = pc_plus4(pcf_q);
                        state_d = IDLE;
                    end else if (imem_valid) begin
                        hold_d  = imem_rdata;
                        instr_d = instr_q;
                        valid_d = valid_q;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (advance_s) begin
                        instr_d = hold_q;
                        valid_d = 1'b1;
                        pcd_d   = pcf_q;
                        pcp4_d  = pc_plus4(pcf_q);
                        pcf_d   = pc_plus4(pcf_q);
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                DROP: begin
                    state_d = imem_valid ? IDLE : DROP;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == WAIT) || (state_d == DROP);
    end

    // Fetch FSM, PC, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pcf_q   <= RESET_PC;
            hold_q  <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            pcd_q   <= 32'h0000_0000;
            pcp4_q  <= 32'h0000_0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            busy_q  <= busy_d;
        end
    end

    // Request is a decode of the registered state, suppressed while reset is held
    assign imem_req   = (state_q == IDLE) && !rst;
    assign imem_addr  = pcf_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcp4_q;
    assign validD     = valid_q;
    assign fetch_busy = busy_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a default instance plus one with RESET_PC at the
// top of the address space (shared stimulus) for the PC wrap case.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_write, stallF_load_hazard, PCSrcE, imem_valid;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req, validD, fetch_busy;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
    logic        imem_req2, validD2, fetch_busy2;
    logic [31:0] imem_addr2, InstrD2, PCD2, PCPlus4D2;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .stallF_load_hazard(stallF_load_hazard),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .validD(validD), .fetch_busy(fetch_busy)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .pc_write(pc_write), .stallF_load_hazard(stallF_load_hazard),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(InstrD2), .PCD(PCD2),
        .PCPlus4D(PCPlus4D2), .validD(validD2), .fetch_busy(fetch_busy2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic st, input logic br, input logic [31:0] tgt,
                         input logic v, input logic [31:0] rd);
        pc_write           = pw;
        stallF_load_hazard = st;
        PCSrcE             = br;
        PCTargetE          = tgt;
        imem_valid         = v;
        imem_rdata         = rd;
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'hDEAD_BEEF);
        cyc();
        cyc();
        vectors++; if ({imem_req, fetch_busy, validD} !== 3'b000) begin miscompares++; $display("FAIL rst_ctl: got %b want %b", {imem_req, fetch_busy, validD}, 3'b000); end
        vectors++; if ({InstrD, PCD, PCPlus4D} !== {NOP, 32'h0, 32'h0}) begin miscompares++; $display("FAIL rst_ifid: got %h want %h", {InstrD, PCD, PCPlus4D}, {NOP, 32'h0, 32'h0}); end
        vectors++; if ({imem_addr, imem_addr2} !== {32'h0, 32'hFFFF_FFFC}) begin miscompares++; $display("FAIL rst_pc: got %h want %h", {imem_addr, imem_addr2}, {32'h0, 32'hFFFF_FFFC}); end
        rst = 1'b0;
        drive_idle();
        vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rst_first_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0}); end
    endtask

    task automatic test_straight_line();
        logic [31:0] prog [3];
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0020_0113;
        prog[2] = 32'h0030_0193;
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'(i * 4)}) begin miscompares++; $display("FAIL sl_req%0d: got %h want %h", i, {imem_req, imem_addr}, {1'b1, 32'(i * 4)}); end
            cyc();
            vectors++; if ({fetch_busy, validD, InstrD} !== {1'b1, 1'b0, NOP}) begin miscompares++; $display("FAIL sl_bubble%0d: got %h want %h", i, {fetch_busy, validD, InstrD}, {1'b1, 1'b0, NOP}); end
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, prog[i]);
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL sl_noreq%0d: got %b want %b", i, imem_req, 1'b0); end
            cyc();
            vectors++; if ({validD, InstrD, PCD, PCPlus4D, fetch_busy} !== {1'b1, prog[i], 32'(i * 4), 32'(i * 4 + 4), 1'b0}) begin miscompares++; $display("FAIL sl_ifid%0d: got %h want %h", i, {validD, InstrD, PCD, PCPlus4D, fetch_busy}, {1'b1, prog[i], 32'(i * 4), 32'(i * 4 + 4), 1'b0}); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_idle();
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
        cyc();
        vectors++; if ({validD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin miscompares++; $display("FAIL lu_hold_ifid: got %h want %h", {validD, InstrD, PCD, PCPlus4D}, {1'b0, NOP, 32'h0, 32'h0}); end
        vectors++; if ({imem_req, fetch_busy} !== 2'b00) begin miscompares++; $display("FAIL lu_hold_ctl: got %b want %b", {imem_req, fetch_busy}, 2'b00); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        cyc();
        vectors++; if ({imem_req, validD} !== 2'b00) begin miscompares++; $display("FAIL lu_ignore: got %b want %b", {imem_req, validD}, 2'b00); end
        drive_idle();
        cyc();
        vectors++; if ({validD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0050_0093, 32'h0, 32'h4}) begin miscompares++; $display("FAIL lu_release: got %h want %h", {validD, InstrD, PCD, PCPlus4D}, {1'b1, 32'h0050_0093, 32'h0, 32'h4}); end
        vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL lu_next_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h4}); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        drive_idle();
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        vectors++; if ({validD, PCD} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rw_stall_hold: got %h want %h", {validD, PCD}, {1'b1, 32'h0}); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cyc();
        vectors++; if ({validD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 32'h0, 32'h4}) begin miscompares++; $display("FAIL rw_flush: got %h want %h", {validD, InstrD, PCD, PCPlus4D}, {1'b0, NOP, 32'h0, 32'h4}); end
        vectors++; if ({fetch_busy, imem_req} !== 2'b10) begin miscompares++; $display("FAIL rw_drop: got %b want %b", {fetch_busy, imem_req}, 2'b10); end
        drive_idle();
        cyc();
        vectors++; if ({fetch_busy, imem_req} !== 2'b10) begin miscompares++; $display("FAIL rw_drop_wait: got %b want %b", {fetch_busy, imem_req}, 2'b10); end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBADB_AD00);
        cyc();
        vectors++; if ({validD, InstrD} !== {1'b0, NOP}) begin miscompares++; $display("FAIL rw_stale: got %h want %h", {validD, InstrD}, {1'b0, NOP}); end
        vectors++; if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h0000_0100, 1'b0}) begin miscompares++; $display("FAIL rw_target: got %h want %h", {imem_req, imem_addr, fetch_busy}, {1'b1, 32'h0000_0100, 1'b0}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_idle();
        cyc();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'hBADB_AD01);
        cyc();
        vectors++; if ({validD, InstrD} !== {1'b0, NOP}) begin miscompares++; $display("FAIL sim_flush: got %h want %h", {validD, InstrD}, {1'b0, NOP}); end
        vectors++; if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h0000_0040, 1'b0}) begin miscompares++; $display("FAIL sim_target: got %h want %h", {imem_req, imem_addr, fetch_busy}, {1'b1, 32'h0000_0040, 1'b0}); end
        drive_idle();
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0070_0393);
        cyc();
        vectors++; if ({validD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0070_0393, 32'h40, 32'h44}) begin miscompares++; $display("FAIL sim_refetch: got %h want %h", {validD, InstrD, PCD, PCPlus4D}, {1'b1, 32'h0070_0393, 32'h40, 32'h44}); end
    endtask

    task automatic test_redirect_idle_hold();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b0, 32'h0);
        vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin miscompares++; $display("FAIL ri_old_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h44}); end
        cyc();
        vectors++; if ({fetch_busy, imem_req, validD} !== 3'b100) begin miscompares++; $display("FAIL ri_drop: got %b want %b", {fetch_busy, imem_req, validD}, 3'b100); end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBADB_AD02);
        cyc();
        vectors++; if ({imem_req, imem_addr, validD} !== {1'b1, 32'h0000_0200, 1'b0}) begin miscompares++; $display("FAIL ri_aligned: got %h want %h", {imem_req, imem_addr, validD}, {1'b1, 32'h0000_0200, 1'b0}); end
        drive_idle();
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0080_0413);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        cyc();
        vectors++; if ({imem_req, imem_addr, fetch_busy, validD} !== {1'b1, 32'h0000_0300, 1'b0, 1'b0}) begin miscompares++; $display("FAIL rh_redirect: got %h want %h", {imem_req, imem_addr, fetch_busy, validD}, {1'b1, 32'h0000_0300, 1'b0, 1'b0}); end
        drive_idle();
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0090_0493);
        cyc();
        vectors++; if ({validD, InstrD, PCD} !== {1'b1, 32'h0090_0493, 32'h0000_0300}) begin miscompares++; $display("FAIL rh_refetch: got %h want %h", {validD, InstrD, PCD}, {1'b1, 32'h0090_0493, 32'h0000_0300}); end
    endtask

    task automatic test_wrap();
        do_reset();
        vectors++; if ({imem_req2, imem_addr2} !== {1'b1, 32'hFFFF_FFFC}) begin miscompares++; $display("FAIL wr_first_req: got %h want %h", {imem_req2, imem_addr2}, {1'b1, 32'hFFFF_FFFC}); end
        drive_idle();
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00A0_0513);
        cyc();
        vectors++; if ({validD2, InstrD2, PCD2, PCPlus4D2} !== {1'b1, 32'h00A0_0513, 32'hFFFF_FFFC, 32'h0}) begin miscompares++; $display("FAIL wr_ifid: got %h want %h", {validD2, InstrD2, PCD2, PCPlus4D2}, {1'b1, 32'h00A0_0513, 32'hFFFF_FFFC, 32'h0}); end
        vectors++; if ({imem_req2, imem_addr2} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL wr_next_req: got %h want %h", {imem_req2, imem_addr2}, {1'b1, 32'h0}); end
    endtask

    task automatic test_reset_mid_wait();
        drive_idle();
        cyc();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
        cyc();
        vectors++; if ({imem_req, imem_addr, fetch_busy, validD, InstrD, PCD, PCPlus4D} !== {1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin miscompares++; $display("FAIL rm_state: got %h want %h", {imem_req, imem_addr, fetch_busy, validD, InstrD, PCD, PCPlus4D}, {1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0, 32'h0}); end
        vectors++; if ({imem_addr2, validD2, PCD2} !== {32'hFFFF_FFFC, 1'b0, 32'h0}) begin miscompares++; $display("FAIL rm_wrap_inst: got %h want %h", {imem_addr2, validD2, PCD2}, {32'hFFFF_FFFC, 1'b0, 32'h0}); end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBADB_AD03);
        vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rm_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0}); end
        cyc();
        vectors++; if ({fetch_busy, validD, InstrD} !== {1'b1, 1'b0, NOP}) begin miscompares++; $display("FAIL rm_late_resp: got %h want %h", {fetch_busy, validD, InstrD}, {1'b1, 1'b0, NOP}); end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00B0_0593);
        cyc();
        vectors++; if ({validD, InstrD, PCD} !== {1'b1, 32'h00B0_0593, 32'h0}) begin miscompares++; $display("FAIL rm_fetch: got %h want %h", {validD, InstrD, PCD}, {1'b1, 32'h00B0_0593, 32'h0}); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_straight_line();
        test_load_use();
        test_redirect_wait();
        test_simultaneous();
        test_redirect_idle_hold();
        test_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
